// File: rtl/seq_checker.sv
// Self-check stage for the 5-bit pseudo-random generator: it predicts each sample
// from the previous one, acquires lock after LOCK_N matches and counts mismatches while locked.
module seq_checker #(
  parameter int LOCK_N = 4,
  parameter int LOSS_N = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [4:0]       data,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       state
);

  // in_valid qualifies data for one cycle; there is no ready, and a sample is always accepted.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam int RUN_W  = $clog2(LOCK_N + 1);
  localparam int MISS_W = $clog2(LOSS_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e             state_q, state_d;
  logic [4:0]         prev_q, prev_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [4:0]         expected;
  logic               match;
  logic [RUN_W-1:0]   run_inc;
  logic [MISS_W-1:0]  miss_inc;

  // All-zero is the generator's lock-up state, so it never counts as a match.
  assign expected = {prev_q[3] ^ prev_q[4], prev_q[2] | prev_q[4], prev_q[1], prev_q[0], prev_q[4]};
  assign match    = (data == expected) && (data != 5'b00000);
  assign run_inc  = run_q + RUN_W'(1);
  assign miss_inc = miss_q + MISS_W'(1);

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    run_d   = run_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    if (in_valid) begin
      prev_d = data;
      case (state_q)
        IDLE: begin
          state_d = SEARCH;
          run_d   = '0;
        end
        SEARCH: begin
          if (match) begin
            if (run_inc == RUN_W'(LOCK_N)) begin
              state_d = LOCKED;
              run_d   = '0;
              miss_d  = '0;
            end else begin
              run_d = run_inc;
            end
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            miss_d = '0;
          end else begin
            err_d = 1'b1;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            if (miss_inc == MISS_W'(LOSS_N)) begin
              state_d = SEARCH;
              run_d   = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (clr_cnt) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prev_q  <= '0;
      run_q   <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      run_q   <= run_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign locked  = (state_q == LOCKED);
  assign err     = err_q;
  assign err_cnt = cnt_q;
  assign state   = state_q;

endmodule

// File: tb/tb_seq_checker.sv
// Directed table-driven bench for seq_checker: a default instance and a
// small-counter instance (CNT_W=2, LOSS_N=8) share one set of stimulus signals.
module tb_seq_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [4:0] data;
  logic       clr_cnt;

  logic       a_locked, a_err;
  logic [7:0] a_cnt;
  logic [1:0] a_state;
  logic       b_locked, b_err;
  logic [1:0] b_cnt;
  logic [1:0] b_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       v;
    logic [4:0] d;
    logic       clr;
    logic [1:0] st;
    logic       lk;
    logic       er;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];
  logic [11:0] exp_q[$];

  seq_checker #(.LOCK_N(4), .LOSS_N(2), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data(data), .clr_cnt(clr_cnt),
    .locked(a_locked), .err(a_err), .err_cnt(a_cnt), .state(a_state)
  );

  seq_checker #(.LOCK_N(4), .LOSS_N(8), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data(data), .clr_cnt(clr_cnt),
    .locked(b_locked), .err(b_err), .err_cnt(b_cnt), .state(b_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic v, logic [4:0] d, logic c,
                              logic [1:0] st, logic lk, logic er, logic [7:0] cnt);
    vec_t x;
    x.rst = r; x.v = v; x.d = d; x.clr = c;
    x.st = st; x.lk = lk; x.er = er; x.cnt = cnt;
    return x;
  endfunction

  // driver: apply one vector on the falling edge, let the rising edge sample it
  task automatic drive(input vec_t x);
    @(negedge clk);
    rst      = x.rst;
    in_valid = x.v;
    data     = x.d;
    clr_cnt  = x.clr;
    exp_q.push_back({x.st, x.lk, x.er, x.cnt});
    @(posedge clk);
    #1;
  endtask

  // scoreboard: pop the expected record and compare against the observed one
  task automatic check(input string name, input int idx, input logic [11:0] act);
    logic [11:0] exp;
    exp = exp_q.pop_front();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got state=%0d locked=%0d err=%0d cnt=%0d want state=%0d locked=%0d err=%0d cnt=%0d",
               name, idx, act[11:10], act[9], act[8], act[7:0],
               exp[11:10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; data = '0; clr_cnt = 1'b0;

    // default instance: reset, lock with gaps, error and loss, relock,
    // non-consecutive misses, clear, reset while locked, zero handling
    tbl_a.push_back(mk(1, 0, 5'b00000, 0, 0, 0, 0, 0));
    tbl_a.push_back(mk(1, 0, 5'b00000, 0, 0, 0, 0, 0));
    tbl_a.push_back(mk(0, 1, 5'b11111, 0, 1, 0, 0, 0));
    tbl_a.push_back(mk(0, 1, 5'b01111, 0, 1, 0, 0, 0));
    tbl_a.push_back(mk(0, 1, 5'b11110, 0, 1, 0, 0, 0));
    tbl_a.push_back(mk(0, 0, 5'b10101, 0, 1, 0, 0, 0));
    tbl_a.push_back(mk(0, 1, 5'b01101, 0, 1, 0, 0, 0));
    tbl_a.push_back(mk(0, 0, 5'b00000, 0, 1, 0, 0, 0));
    tbl_a.push_back(mk(0, 1, 5'b11010, 0, 2, 1, 0, 0));
    tbl_a.push_back(mk(0, 1, 5'b00000, 0, 2, 1, 1, 1));
    tbl_a.push_back(mk(0, 1, 5'b11010, 0, 1, 0, 1, 2));
    tbl_a.push_back(mk(0, 1, 5'b01101, 0, 1, 0, 0, 2));
    tbl_a.push_back(mk(0, 1, 5'b11010, 0, 1, 0, 0, 2));
    tbl_a.push_back(mk(0, 1, 5'b01101, 0, 1, 0, 0, 2));
    tbl_a.push_back(mk(0, 1, 5'b11010, 0, 2, 1, 0, 2));
    tbl_a.push_back(mk(0, 1, 5'b11010, 0, 2, 1, 1, 3));
    tbl_a.push_back(mk(0, 1, 5'b01101, 0, 2, 1, 0, 3));
    tbl_a.push_back(mk(0, 1, 5'b01101, 0, 2, 1, 1, 4));
    tbl_a.push_back(mk(0, 1, 5'b11010, 0, 2, 1, 0, 4));
    tbl_a.push_back(mk(0, 0, 5'b11111, 0, 2, 1, 0, 4));
    tbl_a.push_back(mk(0, 1, 5'b11010, 1, 2, 1, 1, 0));
    tbl_a.push_back(mk(0, 1, 5'b01101, 0, 2, 1, 0, 0));
    tbl_a.push_back(mk(0, 1, 5'b01101, 0, 2, 1, 1, 1));
    tbl_a.push_back(mk(0, 1, 5'b11010, 0, 2, 1, 0, 1));
    tbl_a.push_back(mk(0, 1, 5'b11010, 0, 2, 1, 1, 2));
    tbl_a.push_back(mk(1, 1, 5'b00000, 0, 0, 0, 0, 0));
    tbl_a.push_back(mk(0, 1, 5'b01101, 0, 1, 0, 0, 0));
    tbl_a.push_back(mk(0, 1, 5'b00000, 0, 1, 0, 0, 0));
    tbl_a.push_back(mk(0, 1, 5'b00000, 0, 1, 0, 0, 0));
    tbl_a.push_back(mk(0, 1, 5'b11111, 0, 1, 0, 0, 0));
    tbl_a.push_back(mk(0, 1, 5'b01111, 0, 1, 0, 0, 0));
    tbl_a.push_back(mk(0, 1, 5'b11110, 0, 1, 0, 0, 0));
    tbl_a.push_back(mk(0, 1, 5'b00000, 0, 1, 0, 0, 0));
    tbl_a.push_back(mk(0, 1, 5'b00000, 0, 1, 0, 0, 0));
    tbl_a.push_back(mk(0, 1, 5'b11111, 0, 1, 0, 0, 0));
    tbl_a.push_back(mk(0, 1, 5'b01111, 0, 1, 0, 0, 0));
    tbl_a.push_back(mk(0, 1, 5'b11110, 0, 1, 0, 0, 0));
    tbl_a.push_back(mk(0, 1, 5'b01101, 0, 1, 0, 0, 0));
    tbl_a.push_back(mk(0, 1, 5'b11010, 0, 2, 1, 0, 0));

    // small-counter instance: saturation at 3, then clear racing a mismatch
    tbl_b.push_back(mk(1, 0, 5'b00000, 0, 0, 0, 0, 0));
    tbl_b.push_back(mk(0, 1, 5'b11111, 0, 1, 0, 0, 0));
    tbl_b.push_back(mk(0, 1, 5'b01111, 0, 1, 0, 0, 0));
    tbl_b.push_back(mk(0, 1, 5'b11110, 0, 1, 0, 0, 0));
    tbl_b.push_back(mk(0, 1, 5'b01101, 0, 1, 0, 0, 0));
    tbl_b.push_back(mk(0, 1, 5'b11010, 0, 2, 1, 0, 0));
    tbl_b.push_back(mk(0, 1, 5'b11010, 0, 2, 1, 1, 1));
    tbl_b.push_back(mk(0, 1, 5'b01101, 0, 2, 1, 0, 1));
    tbl_b.push_back(mk(0, 1, 5'b01101, 0, 2, 1, 1, 2));
    tbl_b.push_back(mk(0, 1, 5'b11010, 0, 2, 1, 0, 2));
    tbl_b.push_back(mk(0, 1, 5'b11010, 0, 2, 1, 1, 3));
    tbl_b.push_back(mk(0, 1, 5'b01101, 0, 2, 1, 0, 3));
    tbl_b.push_back(mk(0, 1, 5'b01101, 0, 2, 1, 1, 3));
    tbl_b.push_back(mk(0, 1, 5'b11010, 0, 2, 1, 0, 3));
    tbl_b.push_back(mk(0, 1, 5'b11010, 0, 2, 1, 1, 3));
    tbl_b.push_back(mk(0, 1, 5'b01101, 0, 2, 1, 0, 3));
    tbl_b.push_back(mk(0, 1, 5'b01101, 1, 2, 1, 1, 0));
    tbl_b.push_back(mk(0, 1, 5'b11010, 0, 2, 1, 0, 0));

    foreach (tbl_a[i]) begin
      drive(tbl_a[i]);
      check("dflt", i, {a_state, a_locked, a_err, a_cnt});
    end

    foreach (tbl_b[i]) begin
      drive(tbl_b[i]);
      check("sat", i, {b_state, b_locked, b_err, 6'b0, b_cnt});
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
